product_accumulator: RTL and testbench

Sequential consumer placed directly downstream of the 4x4 array multiplier. It takes the multiplier's 8-bit product P through a valid/ready handshake. It sums a programmed number of products into a saturating accumulator, then presents the result with its own valid/ready handshake. It is the accumulate half of a dot-product / MAC datapath. The multiplier itself stays purely combinational.

---
 rtl/product_accumulator.sv | 98 +++++++++
 tb/tb_product_accumulator.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Purpose : sums a programmed number of 8-bit multiplier products into a
//           saturating ACC_W-bit accumulator and presents the job result.
// Latency : acc_out updates 1 cycle after each product transfer; out_valid
//           rises the cycle after the final transfer.
// Backpressure: prod_ready is high only while collecting products.
//           out_valid holds the result until out_ready is seen.
//
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   start, len       - job request (IDLE only) and product count
//   prod, prod_valid,
//   prod_ready       - product input handshake
//   acc_out, out_valid,
//   out_ready        - result output handshake (acc_out also shows the running sum)
//   overflow         - sticky saturation flag for the current job
//   busy             - job in progress (ACC or HOLD)
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [7:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W:0]   sum;
  logic             xfer;

  // One extra bit catches the carry out of the accumulator for saturation.
  assign sum  = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, prod};
  assign xfer = prod_valid && (state == ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out   <= '0;
            overflow  <= 1'b0;
            remaining <= len;
            // A zero-length job goes straight to presenting a zero result.
            state     <= (len == '0) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (xfer) begin
            if (sum[ACC_W]) begin
              acc_out  <= '1;
              overflow <= 1'b1;
            end else begin
              acc_out  <= sum[ACC_W-1:0];
            end
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // start in this cycle is deliberately dropped; a new job must
          // be requested once back in IDLE.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the registered state only.
  assign prod_ready = (state == ACC);
  assign out_valid  = (state == HOLD);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Purpose : self-checking bench for product_accumulator (default widths and ACC_W=10).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: out_ready is held low in selected scenarios to stall the result.
module tb_product_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic [7:0] prod;
  logic       prod_valid;
  logic       out_ready;

  logic        d_prod_ready, d_out_valid, d_overflow, d_busy;
  logic [11:0] d_acc;
  logic        s_prod_ready, s_out_valid, s_overflow, s_busy;
  logic [9:0]  s_acc;

  product_accumulator #(.ACC_W(12), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(d_prod_ready),
    .acc_out(d_acc), .out_valid(d_out_valid), .out_ready(out_ready),
    .overflow(d_overflow), .busy(d_busy)
  );

  product_accumulator #(.ACC_W(10), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(s_prod_ready),
    .acc_out(s_acc), .out_valid(s_out_valid), .out_ready(out_ready),
    .overflow(s_overflow), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc;
    bit ov;
    int sacc;
    bit sov;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc, s_acc_m;
  bit   m_ov, s_ov_m;
  int   tests_run;
  int   tests_failed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and reset the reference models.
  task automatic start_job(input int n);
    start = 1'b1;
    len   = 4'(n);
    tick();
    start   = 1'b0;
    m_acc   = 0;
    m_ov    = 1'b0;
    s_acc_m = 0;
    s_ov_m  = 1'b0;
  endtask

  // Present one product for one cycle; the expected sums go to the scoreboard.
  task automatic send(input int p);
    exp_t e;
    prod       = 8'(p);
    prod_valid = 1'b1;
    m_acc = m_acc + p;
    if (m_acc > 4095) begin m_acc = 4095; m_ov = 1'b1; end
    s_acc_m = s_acc_m + p;
    if (s_acc_m > 1023) begin s_acc_m = 1023; s_ov_m = 1'b1; end
    e.acc = m_acc; e.ov = m_ov; e.sacc = s_acc_m; e.sov = s_ov_m;
    exp_q.push_back(e);
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({d_busy, d_prod_ready, d_out_valid, d_overflow} !== 4'b0000 || d_acc !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: flags=%b acc=%0d, want flags=0000 acc=0",
               {d_busy, d_prod_ready, d_out_valid, d_overflow}, d_acc);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   vals[3] = '{225, 6, 0};
    out_ready = 1'b1;
    start_job(3);
    tests_run++;
    if ({d_busy, d_prod_ready, d_out_valid} !== 3'b110 || d_acc !== 12'd0) begin
      tests_failed++;
      $display("FAIL basic_enter_acc: flags=%b acc=%0d, want 110 acc=0",
               {d_busy, d_prod_ready, d_out_valid}, d_acc);
    end
    for (int i = 0; i < 3; i++) begin
      send(vals[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (d_acc !== 12'(e.acc) || d_out_valid !== (i == 2)) begin
        tests_failed++;
        $display("FAIL basic_step%0d: acc=%0d out_valid=%b, want acc=%0d out_valid=%b",
                 i, d_acc, d_out_valid, e.acc, (i == 2));
      end
    end
    tests_run++;
    if (d_acc !== 12'd231 || d_overflow !== 1'b0 || d_prod_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: acc=%0d ov=%b prod_ready=%b, want 231 0 0",
               d_acc, d_overflow, d_prod_ready);
    end
    tick();
    tests_run++;
    if ({d_busy, d_out_valid} !== 2'b00 || d_acc !== 12'd231) begin
      tests_failed++;
      $display("FAIL basic_idle: busy=%b out_valid=%b acc=%0d, want 0 0 231",
               d_busy, d_out_valid, d_acc);
    end
  endtask

  task automatic test_gaps_backpressure();
    exp_t e;
    out_ready = 1'b0;
    start_job(2);
    for (int i = 0; i < 3; i++) tick();
    send(10);
    e = exp_q.pop_front();
    tests_run++;
    if (d_acc !== 12'(e.acc) || d_prod_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL gaps_first: acc=%0d prod_ready=%b, want %0d 1", d_acc, d_prod_ready, e.acc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (d_prod_ready !== 1'b1 || d_acc !== 12'd10 || d_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL gaps_wait%0d: prod_ready=%b acc=%0d out_valid=%b, want 1 10 0",
                 i, d_prod_ready, d_acc, d_out_valid);
      end
    end
    send(20);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (d_out_valid !== 1'b1 || d_acc !== 12'(e.acc) || d_prod_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: out_valid=%b acc=%0d prod_ready=%b, want 1 %0d 0",
                 i, d_out_valid, d_acc, d_prod_ready, e.acc);
      end
      start = (i == 2);
      len   = 4'd5;
      tick();
      start = 1'b0;
    end
    // Release the result with start asserted in the exit cycle: it must be ignored.
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if ({d_busy, d_out_valid, d_prod_ready} !== 3'b000 || d_acc !== 12'd30) begin
      tests_failed++;
      $display("FAIL hold_exit: flags=%b acc=%0d, want 000 acc=30",
               {d_busy, d_out_valid, d_prod_ready}, d_acc);
    end
    tick();
    tests_run++;
    if (d_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_start_ignored: busy=%b, want 0", d_busy);
    end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b0;
    start_job(0);
    tests_run++;
    if ({d_busy, d_prod_ready, d_out_valid, d_overflow} !== 4'b1010 || d_acc !== 12'd0) begin
      tests_failed++;
      $display("FAIL zero_len: flags=%b acc=%0d, want 1010 acc=0",
               {d_busy, d_prod_ready, d_out_valid, d_overflow}, d_acc);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if ({d_busy, d_prod_ready, d_out_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL zero_len_exit: flags=%b, want 000", {d_busy, d_prod_ready, d_out_valid});
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    out_ready = 1'b0;
    start_job(5);
    for (int i = 0; i < 5; i++) begin
      send(225);
      e = exp_q.pop_front();
      tests_run++;
      if (s_acc !== 10'(e.sacc) || s_overflow !== e.sov || d_acc !== 12'(e.acc)) begin
        tests_failed++;
        $display("FAIL sat_step%0d: acc10=%0d ov10=%b acc12=%0d, want %0d %b %0d",
                 i, s_acc, s_overflow, d_acc, e.sacc, e.sov, e.acc);
      end
    end
    tests_run++;
    if (s_acc !== 10'd1023 || s_overflow !== 1'b1 || s_out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_result: acc=%0d ov=%b out_valid=%b, want 1023 1 1",
               s_acc, s_overflow, s_out_valid);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (s_overflow !== 1'b1 || s_acc !== 10'd1023) begin
      tests_failed++;
      $display("FAIL sat_sticky_idle: ov=%b acc=%0d, want 1 1023", s_overflow, s_acc);
    end
    start_job(1);
    tests_run++;
    if (s_overflow !== 1'b0 || s_acc !== 10'd0) begin
      tests_failed++;
      $display("FAIL sat_clear: ov=%b acc=%0d, want 0 0", s_overflow, s_acc);
    end
    send(7);
    e = exp_q.pop_front();
    tests_run++;
    if (s_acc !== 10'(e.sacc) || s_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_next_job: acc=%0d ov=%b, want %0d 0", s_acc, s_overflow, e.sacc);
    end
    tick();
  endtask

  task automatic test_max_len();
    exp_t e;
    int   bad;
    out_ready = 1'b0;
    start_job(15);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (d_prod_ready !== 1'b1 || d_out_valid !== 1'b0) bad++;
      send(225);
      e = exp_q.pop_front();
      if (d_acc !== 12'(e.acc)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL max_len_steps: %0d step errors, want 0", bad);
    end
    tests_run++;
    if (d_acc !== 12'hD2F || d_overflow !== 1'b0 || d_out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL max_len_result: acc=%0d ov=%b out_valid=%b, want 3375 0 1",
               d_acc, d_overflow, d_out_valid);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_job();
    exp_t e;
    out_ready = 1'b1;
    start_job(4);
    send(50);
    send(60);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({d_busy, d_prod_ready, d_out_valid, d_overflow} !== 4'b0000 || d_acc !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_async: flags=%b acc=%0d, want 0000 acc=0",
               {d_busy, d_prod_ready, d_out_valid, d_overflow}, d_acc);
    end
    #1 rst_n = 1'b1;
    tick();
    tests_run++;
    if (d_busy !== 1'b0 || d_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b out_valid=%b, want 0 0", d_busy, d_out_valid);
    end
    start_job(1);
    send(7);
    e = exp_q.pop_front();
    tests_run++;
    if (d_acc !== 12'(e.acc) || d_out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_new_job: acc=%0d out_valid=%b, want %0d 1", d_acc, d_out_valid, e.acc);
    end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    start      = 1'b0;
    len        = 4'd0;
    prod       = 8'd0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    #12;
    test_reset();
    #1 rst_n = 1'b1;
    tick();
    test_basic();
    test_gaps_backpressure();
    test_zero_len();
    test_saturation();
    test_max_len();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
